// File: rtl/rv_register_bank.sv
// Host-facing ready/valid bridge to NUM_REGS device registers: buffered device
// changes are reported round-robin, host writes fan out as per-register pulses.
module rv_register_bank #(
  parameter int NUM_REGS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                           CLK_I,
  input  logic                           RST_NI,
  input  logic                           READ_ENABLE_I,
  input  logic                           READ_READY_I,
  output logic                           READ_VALID_O,
  output logic [ADDR_WIDTH-1:0]          READ_ADDR_O,
  output logic [DATA_WIDTH-1:0]          READ_DATA_O,
  input  logic                           WRITE_ENABLE_I,
  output logic                           WRITE_READY_O,
  input  logic                           WRITE_VALID_I,
  input  logic [ADDR_WIDTH-1:0]          WRITE_ADDR_I,
  input  logic [DATA_WIDTH-1:0]          WRITE_DATA_I,
  output logic                           WRITE_ERR_O,
  output logic [NUM_REGS-1:0]            UPDATE_O,
  output logic [NUM_REGS*DATA_WIDTH-1:0] DATA_O,
  input  logic [NUM_REGS-1:0]            CHANGE_I,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] DATA_I,
  output logic [NUM_REGS-1:0]            READ_O,
  output logic [1:0]                     READ_STATE_O
);

  // Read handshake: a beat transfers on a rising edge where READ_VALID_O and
  // READ_READY_I are both high; address/data are held stable until then.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POLL  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]            state_q;
  logic [NUM_REGS-1:0]   pend_q;
  logic [NUM_REGS-1:0]   pend_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] live     [NUM_REGS];
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  grant_found;
  logic [ADDR_WIDTH-1:0] grant_idx;
  logic [ADDR_WIDTH-1:0] cand;
  int                    j;
  logic                  grant_take;
  logic                  wr_fire;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_live
    assign live[g] = DATA_I[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign READ_STATE_O  = state_q;
  assign WRITE_READY_O = WRITE_ENABLE_I;
  assign wr_fire       = WRITE_VALID_I && WRITE_ENABLE_I;
  assign grant_take    = (state_q == ST_IDLE) && READ_ENABLE_I && grant_found;
  assign ptr_next      = (32'(READ_ADDR_O) == 32'(NUM_REGS - 1)) ? '0
                                                                 : READ_ADDR_O + ADDR_WIDTH'(1);

  // First pending index at or after the pointer, wrapping at NUM_REGS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    j           = 0;
    for (int k = 0; k < NUM_REGS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REGS) cand = ADDR_WIDTH'(j - NUM_REGS);
      else               cand = ADDR_WIDTH'(j);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A new change wins over the clear, so a change during a grant stays pending.
  always_comb begin
    pend_d = pend_q;
    if (grant_take) pend_d[grant_idx] = 1'b0;
    pend_d = pend_d | CHANGE_I;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      ptr_q        <= '0;
      READ_VALID_O <= 1'b0;
      READ_ADDR_O  <= '0;
      READ_DATA_O  <= '0;
      READ_O       <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      READ_O <= '0;
      pend_q <= pend_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (CHANGE_I[i]) shadow_q[i] <= live[i];
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_take) begin
            READ_ADDR_O  <= grant_idx;
            READ_DATA_O  <= shadow_q[grant_idx];
            READ_VALID_O <= 1'b1;
            state_q      <= ST_VALID;
          end else if (READ_ENABLE_I && READ_READY_I) begin
            state_q <= ST_POLL;
          end
        end
        ST_POLL: begin
          READ_ADDR_O  <= ptr_q;
          READ_DATA_O  <= live[ptr_q];
          READ_VALID_O <= 1'b1;
          state_q      <= ST_VALID;
        end
        ST_VALID: begin
          if (READ_READY_I) begin
            READ_VALID_O <= 1'b0;
            READ_O       <= NUM_REGS'(1) << READ_ADDR_O;
            ptr_q        <= ptr_next;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          READ_VALID_O <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      UPDATE_O    <= '0;
      WRITE_ERR_O <= 1'b0;
      DATA_O      <= '0;
    end else begin
      UPDATE_O    <= '0;
      WRITE_ERR_O <= 1'b0;
      if (wr_fire) begin
        if (32'(WRITE_ADDR_I) < 32'(NUM_REGS)) begin
          UPDATE_O <= NUM_REGS'(1) << WRITE_ADDR_I;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(WRITE_ADDR_I) == 32'(i)) DATA_O[i*DATA_WIDTH +: DATA_WIDTH] <= WRITE_DATA_I;
          end
        end else begin
          WRITE_ERR_O <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_register_bank.sv
// Self-checking bench for rv_register_bank: read beats are scoreboarded through
// an expected queue, write effects are checked directly on both a 4- and 3-register bank.
module tb_rv_register_bank;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam logic [1:0] ST_VALID = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          ren = 1'b0, rready = 1'b0;
  logic          wen = 1'b0, wvalid = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [N-1:0]  change = '0;
  logic [N*DW-1:0] din = '0;

  logic          r_valid, w_ready, w_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [N-1:0]  upd, read_o;
  logic [N*DW-1:0] dout;
  logic [1:0]    state;

  logic          r3_valid, w3_ready, w3_err;
  logic [AW-1:0] r3_addr;
  logic [DW-1:0] r3_data;
  logic [2:0]    upd3, read3;
  logic [3*DW-1:0] dout3;
  logic [1:0]    state3;

  rv_register_bank #(.NUM_REGS(N), .DATA_WIDTH(DW)) dut (
    .CLK_I(clk), .RST_NI(rst_n),
    .READ_ENABLE_I(ren), .READ_READY_I(rready), .READ_VALID_O(r_valid),
    .READ_ADDR_O(r_addr), .READ_DATA_O(r_data),
    .WRITE_ENABLE_I(wen), .WRITE_READY_O(w_ready), .WRITE_VALID_I(wvalid),
    .WRITE_ADDR_I(waddr), .WRITE_DATA_I(wdata), .WRITE_ERR_O(w_err),
    .UPDATE_O(upd), .DATA_O(dout), .CHANGE_I(change), .DATA_I(din),
    .READ_O(read_o), .READ_STATE_O(state)
  );

  rv_register_bank #(.NUM_REGS(3), .DATA_WIDTH(DW)) dut3 (
    .CLK_I(clk), .RST_NI(rst_n),
    .READ_ENABLE_I(1'b0), .READ_READY_I(1'b0), .READ_VALID_O(r3_valid),
    .READ_ADDR_O(r3_addr), .READ_DATA_O(r3_data),
    .WRITE_ENABLE_I(wen), .WRITE_READY_O(w3_ready), .WRITE_VALID_I(wvalid),
    .WRITE_ADDR_I(waddr), .WRITE_DATA_I(wdata), .WRITE_ERR_O(w3_err),
    .UPDATE_O(upd3), .DATA_O(dout3), .CHANGE_I(3'b000), .DATA_I(24'h0),
    .READ_O(read3), .READ_STATE_O(state3)
  );

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [N-1:0]     exp_read_o = '0;
  logic [AW+DW-1:0] beat_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_read_o = '0;
    end else begin
      check("read_o", read_o, exp_read_o);
      exp_read_o = '0;
      if (r_valid && rready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_e = exp_q.pop_front();
          check("beat", {r_addr, r_data}, beat_e);
          exp_read_o = N'(1) << beat_e[AW+DW-1:DW];
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    rready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    rready = 1'b0;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done = 1'b0;
    wvalid = 1'b1; waddr = a; wdata = d;
    for (int t = 0; t < 40 && !done; t++) begin
      wen = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wr_ready", w_ready, wen);
      tick();
      if (wen) done = 1'b1;
    end
    wvalid = 1'b0; wen = 1'b0;
    check("wr_done", done, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_read", {r_valid, r_addr, r_data, read_o, state}, 0);
    check("rst_write", {w_err, upd, w_ready}, 0);
    check("rst_dout", dout, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ren = 1'b1;

    // single change on reg 2, host not ready
    tick();
    din[2*DW +: DW] = 8'hA5; change = 4'b0100;
    exp_q.push_back({2'd2, 8'hA5});
    tick();
    change = '0;
    @(negedge clk); check("t1_lat1", r_valid, 0);
    @(negedge clk); check("t1_lat2", r_valid, 1);
    repeat (3) begin
      @(negedge clk);
      check("t1_hold", {r_valid, r_addr, r_data, state}, {1'b1, 2'd2, 8'hA5, ST_VALID});
    end
    tick();
    drain();
    @(negedge clk); check("t1_drop", r_valid, 0);

    // all four change together: address order, then wrap to 0
    tick();
    apply_reset();
    din = {8'h44, 8'h33, 8'h22, 8'h11}; change = 4'hF;
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), din[i*DW +: DW]});
    tick();
    change = '0;
    drain();
    din[0 +: DW] = 8'h55; change = 4'b0001;
    exp_q.push_back({2'd0, 8'h55});
    tick();
    change = '0;
    drain();

    // poll with nothing pending, pointer = 1
    tick();
    din[1*DW +: DW] = 8'h3C; din[2*DW +: DW] = 8'h77;
    exp_q.push_back({2'd1, 8'h3C});
    exp_q.push_back({2'd2, 8'h77});
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk); check("t3_lat1", r_valid, 0);
    @(negedge clk); check("t3_lat2", r_valid, 1);
    tick();
    drain();

    // change on the presented register while valid is held
    tick();
    din[1*DW +: DW] = 8'h66; change = 4'b0010;
    exp_q.push_back({2'd1, 8'h66});
    tick();
    change = '0;
    repeat (2) @(negedge clk);
    check("t4_first", {r_valid, r_addr, r_data}, {1'b1, 2'd1, 8'h66});
    tick();
    din[1*DW +: DW] = 8'h99; change = 4'b0010;
    exp_q.push_back({2'd1, 8'h99});
    tick();
    change = '0;
    @(negedge clk);
    check("t4_hold", {r_valid, r_data}, {1'b1, 8'h66});
    tick();
    drain();

    // writes: addr 3 valid on 4-reg bank, out of range on 3-reg bank
    tick();
    do_write(2'd3, 8'h5A);
    check("w3_update", upd, 4'b1000);
    check("w3_slice", dout[3*DW +: DW], 8'h5A);
    check("w3_err", w_err, 0);
    check("w3_err_small", {w3_err, upd3}, {1'b1, 3'b000});
    check("w3_dout_small", dout3, 0);
    @(negedge clk);
    check("w3_pulse_end", {w_err, upd, w3_err, upd3}, 0);
    do_write(2'd0, 8'hC3);
    check("w0_update", upd, 4'b0001);
    check("w0_dout", dout, {8'h5A, 8'h00, 8'h00, 8'hC3});
    check("w0_small", {w3_err, upd3, dout3[7:0]}, {1'b0, 3'b001, 8'hC3});

    // asynchronous reset while a beat is presented
    tick();
    din[0 +: DW] = 8'hEE; change = 4'b0001;
    exp_q.push_back({2'd0, 8'hEE});
    tick();
    change = '0;
    repeat (2) @(negedge clk);
    check("t6_valid", r_valid, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_read", {r_valid, r_addr, r_data, read_o, state}, 0);
    check("t6_rst_write", {w_err, upd, dout}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_stale", r_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_register_bank.md
# rv_register_bank

Multi-register successor to the single-register ready/valid interface: bridges a host-side ready/valid read and write channel to `NUM_REGS` device registers of `DATA_WIDTH` bits each. Device-initiated changes are buffered per register and reported to the host by a round-robin arbiter. Host writes are addressed and fan out as per-register update pulses. It sits between the debug transport and the trace-buffer control/status registers.

## Interface
- `NUM_REGS`, 4: number of device registers (≥2).
- `DATA_WIDTH`, 8: width of each register.
- `ADDR_WIDTH`, `$clog2(NUM_REGS)`: register address width.
- `CLK_I` in 1: single clock, rising edge.
- `RST_NI` in 1: asynchronous, active-low reset.
- `READ_ENABLE_I` in 1: permits new read transfers to start.
- `READ_READY_I` in 1: host accepts read data; when held with nothing pending, it requests a poll.
- `READ_VALID_O` out 1: read beat valid.
- `READ_ADDR_O` out `ADDR_WIDTH`: register index of the beat.
- `READ_DATA_O` out `DATA_WIDTH`: register value of the beat.
- `WRITE_ENABLE_I` in 1: permits writes.
- `WRITE_READY_O` out 1: write accepted this cycle.
- `WRITE_VALID_I` in 1: write beat valid.
- `WRITE_ADDR_I` in `ADDR_WIDTH`: target register.
- `WRITE_DATA_I` in `DATA_WIDTH`: write value.
- `WRITE_ERR_O` out 1: one-cycle pulse; the accepted address was ≥ `NUM_REGS`.
- `UPDATE_O` out `NUM_REGS`: one-cycle pulse per register on write.
- `DATA_O` out `NUM_REGS*DATA_WIDTH`: last written value per register; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `CHANGE_I` in `NUM_REGS`: device flags that the register value changed.
- `DATA_I` in `NUM_REGS*DATA_WIDTH`: device register values.
- `READ_O` out `NUM_REGS`: one-cycle pulse when the host consumed register i.

## Operation
- Reset state: all outputs 0, shadow registers 0, pending flags 0, round-robin pointer 0, read FSM in IDLE.
- Change capture: on an edge where `CHANGE_I[i]`=1, capture `DATA_I[i]` into shadow i and set pending[i].
- Read FSM has three states:
  - IDLE, when `READ_ENABLE_I`=1 and some pending bit is set: choose the first pending index at or after the pointer (wrapping). Load `READ_ADDR_O`/`READ_DATA_O` from that shadow, clear pending[idx], set `READ_VALID_O`, and go to VALID.
  - IDLE, when `READ_ENABLE_I`=1, no pending bit, and `READ_READY_I`=1: go to POLL.
  - POLL: load live `DATA_I[pointer]` and address = pointer, set `READ_VALID_O`, go to VALID.
  - VALID: hold address and data stable until `READ_VALID_O && READ_READY_I`. On that handshake: pulse `READ_O[addr]`, drop valid, set pointer = addr+1 (wrapping at `NUM_REGS`), go to IDLE.
- Dropping `READ_ENABLE_I` in VALID does not withdraw the beat; it only blocks new starts.
- A `CHANGE_I` for the register currently being presented re-sets pending. The presented data is not altered; the new value is delivered in a later beat.
- Write side:
  - `WRITE_READY_O` = `WRITE_ENABLE_I` (combinational, no backpressure otherwise).
  - A handshake with address < `NUM_REGS` loads that `DATA_O` slice and pulses `UPDATE_O[addr]` in the following cycle.
  - A handshake with address ≥ `NUM_REGS` is dropped and `WRITE_ERR_O` pulses.
- Read and write are independent and may hand-shake in the same cycle.

## Timing
- Change to valid: `CHANGE_I` sampled at edge E, pending visible after E, `READ_VALID_O` high after E+1 (2-cycle latency from IDLE).
- Poll: `READ_READY_I` high in IDLE at edge E moves to POLL; `READ_VALID_O` high after E+1.
- Read handshake at edge E: `READ_VALID_O` low and `READ_O` pulse high during the cycle after E. The next beat's valid rises no earlier than after E+1, so there is one idle cycle minimum between beats.
- Write handshake at edge E: `DATA_O` slice and `UPDATE_O`/`WRITE_ERR_O` are valid during the cycle after E. Throughput is one write per cycle.
- Asynchronous reset mid-transfer: valid drops immediately, pending is cleared, and no `READ_O` or `UPDATE_O` pulse is emitted.

## Test plan
- Reset, then a `CHANGE_I`=4'b0100 pulse with reg 2 = 8'hA5 and `READ_READY_I`=0. Required: `READ_VALID_O` high 2 cycles later with addr 2 and data A5, held until ready. Ready pulse → `READ_O`=4'b0100 for one cycle.
- All four registers pulse `CHANGE_I` in the same cycle; host always ready. Required: beats in address order 0,1,2,3. Then a change on reg 0 → next beat addr 0 (pointer has wrapped).
- Nothing pending, `READ_ENABLE_I`=1, `READ_READY_I` held with pointer=1 and `DATA_I` reg1=8'h3C. Required: valid after 2 cycles with addr 1, data 3C. The next poll returns addr 2.
- `CHANGE_I` on the presented register while valid is held, with a new value. Required: the current beat's data is unchanged; after the handshake a second beat carries the new value.
- Random `WRITE_ENABLE_I`; write addr 3, data 8'h5A. Required: `UPDATE_O`=4'b1000 for one cycle and `DATA_O` slice 3 = 5A. When NUM_REGS=3 with addr 3: `WRITE_ERR_O` pulses and no `UPDATE_O` bit is set.
- Assert `RST_NI`=0 while a beat is valid. Required: all outputs 0 immediately. After release, no stale pending beat appears.
